// File: rtl/raster_primitive_sequencer.sv
// Assembles SETVERTEX operands into triangles, queues them and issues them to the rasterizer.
// Define RAST_SEQ_STRIP_EN for triangle-strip assembly; otherwise triangle-list only.
module raster_primitive_sequencer #(
  parameter int TRI_DEPTH    = 4,
  parameter int CNT_WIDTH    = 16,
  parameter int OPCODE_WIDTH = 8,
  parameter int VREG_WIDTH   = 32,
  parameter logic [OPCODE_WIDTH-1:0] OP_STARTPRIMITIVE = OPCODE_WIDTH'('h10),
  parameter logic [OPCODE_WIDTH-1:0] OP_SETVERTEX      = OPCODE_WIDTH'('h11),
  parameter logic [OPCODE_WIDTH-1:0] OP_ENDPRIMITIVE   = OPCODE_WIDTH'('h12),
  parameter logic [OPCODE_WIDTH-1:0] OP_DRAW           = OPCODE_WIDTH'('h13)
) (
  input  logic                    I_CLOCK,
  input  logic                    I_RESET_N,
  input  logic                    I_Valid,
  input  logic [OPCODE_WIDTH-1:0] I_Opcode,
  input  logic [VREG_WIDTH-1:0]   I_Vertex,
  input  logic [VREG_WIDTH-1:0]   I_ColorIn,
  output logic                    O_Ready,
  output logic                    O_TriValid,
  input  logic                    I_RastReady,
  input  logic                    I_RastIdle,
  output logic [VREG_WIDTH-1:0]   O_V0,
  output logic [VREG_WIDTH-1:0]   O_V1,
  output logic [VREG_WIDTH-1:0]   O_V2,
  output logic [VREG_WIDTH-1:0]   O_C0,
  output logic [VREG_WIDTH-1:0]   O_C1,
  output logic [VREG_WIDTH-1:0]   O_C2,
  output logic                    O_DrawDone,
  output logic                    O_Error,
  output logic [CNT_WIDTH-1:0]    O_TriCount
);
  localparam int PW = $clog2(TRI_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = 6 * VREG_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ASSEMBLE, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [1:0]            vcnt_q, vcnt_d;
  logic                  started_q, started_d;
  logic                  odd_q, odd_d;
  logic [VREG_WIDTH-1:0] sv0_q, sv0_d, sv1_q, sv1_d, sc0_q, sc0_d, sc1_q, sc1_d;
  logic [TW-1:0]         tri_mem_q [0:TRI_DEPTH-1];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  ready_q, tri_valid_q, done_q, done_d, err_q, err_d;
  logic [CNT_WIDTH-1:0]  tri_cnt_q;
  logic                  push;
  logic [TW-1:0]         push_tri;
  logic                  accept, hs, partial;

  assign accept  = I_Valid & ready_q;
  assign hs      = tri_valid_q & I_RastReady;
  // A strip that has already emitted a triangle may end on any vertex.
  assign partial = (vcnt_q != 2'd0) && !started_q;

  always_comb begin
    state_d   = state_q;
    vcnt_d    = vcnt_q;
    started_d = started_q;
    odd_d     = odd_q;
    sv0_d     = sv0_q;
    sv1_d     = sv1_q;
    sc0_d     = sc0_q;
    sc1_d     = sc1_q;
    err_d     = 1'b0;
    done_d    = 1'b0;
    push      = 1'b0;
    push_tri  = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (I_Opcode == OP_STARTPRIMITIVE) begin
            state_d   = S_ASSEMBLE;
            vcnt_d    = 2'd0;
            started_d = 1'b0;
            odd_d     = 1'b0;
          end else if (I_Opcode == OP_SETVERTEX || I_Opcode == OP_ENDPRIMITIVE) begin
            err_d = 1'b1;
          end else if (I_Opcode == OP_DRAW) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_ASSEMBLE: begin
        if (accept) begin
          if (I_Opcode == OP_SETVERTEX) begin
            if (vcnt_q == 2'd2) begin
              push = 1'b1;
`ifdef RAST_SEQ_STRIP_EN
              push_tri  = odd_q ? {sv1_q, sv0_q, I_Vertex, sc1_q, sc0_q, I_ColorIn}
                                : {sv0_q, sv1_q, I_Vertex, sc0_q, sc1_q, I_ColorIn};
              sv0_d     = sv1_q;
              sc0_d     = sc1_q;
              sv1_d     = I_Vertex;
              sc1_d     = I_ColorIn;
              odd_d     = !odd_q;
              started_d = 1'b1;
`else
              push_tri = {sv0_q, sv1_q, I_Vertex, sc0_q, sc1_q, I_ColorIn};
              vcnt_d   = 2'd0;
`endif
            end else if (vcnt_q == 2'd0) begin
              sv0_d  = I_Vertex;
              sc0_d  = I_ColorIn;
              vcnt_d = 2'd1;
            end else begin
              sv1_d  = I_Vertex;
              sc1_d  = I_ColorIn;
              vcnt_d = 2'd2;
            end
          end else if (I_Opcode == OP_ENDPRIMITIVE) begin
            state_d = S_IDLE;
            err_d   = partial;
          end else if (I_Opcode == OP_STARTPRIMITIVE) begin
            vcnt_d    = 2'd0;
            started_d = 1'b0;
            odd_d     = 1'b0;
            err_d     = 1'b1;
          end else if (I_Opcode == OP_DRAW) begin
            state_d = S_DRAIN;
            err_d   = partial;
          end
        end
      end
      default: begin
        if (count_q == '0 && !hs && I_RastIdle) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
    count_d = count_q + CW'(push) - CW'(hs);
  end

  always_ff @(posedge I_CLOCK) begin
    if (!I_RESET_N) begin
      state_q     <= S_IDLE;
      vcnt_q      <= 2'd0;
      started_q   <= 1'b0;
      odd_q       <= 1'b0;
      sv0_q       <= '0;
      sv1_q       <= '0;
      sc0_q       <= '0;
      sc1_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_q     <= 1'b0;
      tri_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      tri_cnt_q   <= '0;
      for (int i = 0; i < TRI_DEPTH; i++) tri_mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      vcnt_q      <= vcnt_d;
      started_q   <= started_d;
      odd_q       <= odd_d;
      sv0_q       <= sv0_d;
      sv1_q       <= sv1_d;
      sc0_q       <= sc0_d;
      sc1_q       <= sc1_d;
      count_q     <= count_d;
      // Flags are registered from next-state so full/drain stalls upstream without a bubble of overflow.
      ready_q     <= (count_d != CW'(TRI_DEPTH)) && (state_d != S_DRAIN);
      tri_valid_q <= (count_d != '0);
      done_q      <= done_d;
      err_q       <= err_d;
      if (push) begin
        tri_mem_q[wr_ptr_q] <= push_tri;
        wr_ptr_q            <= wr_ptr_q + PW'(1);
      end
      if (hs) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        if (tri_cnt_q != '1) tri_cnt_q <= tri_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign O_Ready    = ready_q;
  assign O_TriValid = tri_valid_q;
  assign O_DrawDone = done_q;
  assign O_Error    = err_q;
  assign O_TriCount = tri_cnt_q;
  assign {O_V0, O_V1, O_V2, O_C0, O_C1, O_C2} = tri_mem_q[rd_ptr_q];
endmodule

// File: tb/tb_raster_primitive_sequencer.sv
// Directed, table-driven bench for raster_primitive_sequencer (list mode unless RAST_SEQ_STRIP_EN).
module tb_raster_primitive_sequencer;
  localparam logic [7:0] OPS = 8'h10, OPV = 8'h11, OPE = 8'h12, OPD = 8'h13, OPX = 8'hFF;

  logic        clk = 1'b0;
  logic        rst_n, valid, rast_ready, rast_idle;
  logic [7:0]  opcode;
  logic [31:0] vtx, col;
  logic        ready, tri_valid, draw_done, err;
  logic [31:0] v0, v1, v2, c0, c1, c2;
  logic [15:0] tri_count;

  int checks = 0;
  int errors = 0;
  logic [127:0] mon[$];

  always #5 clk = ~clk;

  raster_primitive_sequencer dut (
    .I_CLOCK(clk), .I_RESET_N(rst_n), .I_Valid(valid), .I_Opcode(opcode),
    .I_Vertex(vtx), .I_ColorIn(col), .O_Ready(ready), .O_TriValid(tri_valid),
    .I_RastReady(rast_ready), .I_RastIdle(rast_idle),
    .O_V0(v0), .O_V1(v1), .O_V2(v2), .O_C0(c0), .O_C1(c1), .O_C2(c2),
    .O_DrawDone(draw_done), .O_Error(err), .O_TriCount(tri_count)
  );

  // Record every issued triangle at the handshake.
  always @(negedge clk)
    if (rst_n && tri_valid && rast_ready) mon.push_back({v0, v1, v2, c0});

  typedef struct {
    logic v; logic [7:0] op; logic [31:0] vx; logic [31:0] cx;
    logic rr; logic e_rdy; logic e_tv; logic e_err; logic e_done;
    logic [15:0] e_cnt; logic [31:0] ev; logic [31:0] ec;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [7:0] op, logic [31:0] vx, logic [31:0] cx,
                              logic e_rdy, logic e_tv, logic e_err, logic e_done,
                              logic [15:0] e_cnt, logic [31:0] ev = 0, logic [31:0] ec = 0);
    vec_t r;
    r.v = v; r.op = op; r.vx = vx; r.cx = cx; r.rr = 1'b1;
    r.e_rdy = e_rdy; r.e_tv = e_tv; r.e_err = e_err; r.e_done = e_done;
    r.e_cnt = e_cnt; r.ev = ev; r.ec = ec;
    return r;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [7:0] op, logic [31:0] vx, logic [31:0] cx);
    logic acc;
    acc = 1'b0;
    valid = 1'b1; opcode = op; vtx = vx; col = cx;
    for (int k = 0; k < 64 && !acc; k++) begin
      acc = ready;
      step();
    end
    valid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
    $display("send op=%h v=%0h c=%0h ready=%b tv=%b err=%b cnt=%0d", op, vx, cx, ready, tri_valid, err, tri_count);
  endtask

  task automatic wait_cnt(logic [15:0] target);
    for (int k = 0; k < 100 && tri_count != target; k++) step();
    chk("tri_count_wait", tri_count, target);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    mon.delete();
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; opcode = '0; vtx = '0; col = '0;
    rast_ready = 1'b1; rast_idle = 1'b1;

    // Reset state
    step(); step();
    chk("rst_ready", ready, 0);
    chk("rst_tv", tri_valid, 0);
    chk("rst_cnt", tri_count, 0);
    chk("rst_err", err, 0);
    chk("rst_done", draw_done, 0);
    rst_n = 1'b1;
    step();
    chk("ready_after_release", ready, 1);

    //          v  op   vx  cx     rdy tv err done cnt
    tbl.push_back(mk(1, OPS, 0, 0,    1, 0, 0, 0, 0));
    tbl.push_back(mk(1, OPV, 1, 'hA,  1, 0, 0, 0, 0));
    tbl.push_back(mk(1, OPV, 2, 'hB,  1, 0, 0, 0, 0));
    tbl.push_back(mk(1, OPV, 3, 'hC,  1, 1, 0, 0, 0, 1, 'hA));
    tbl.push_back(mk(0, OPX, 0, 0,    1, 0, 0, 0, 1));
    tbl.push_back(mk(1, OPE, 0, 0,    1, 0, 0, 0, 1));
    tbl.push_back(mk(1, OPV, 7, 7,    1, 0, 1, 0, 1));
    tbl.push_back(mk(0, OPX, 0, 0,    1, 0, 0, 0, 1));
    tbl.push_back(mk(1, OPS, 0, 0,    1, 0, 0, 0, 1));
    tbl.push_back(mk(1, OPV, 4, 4,    1, 0, 0, 0, 1));
    tbl.push_back(mk(1, OPV, 5, 5,    1, 0, 0, 0, 1));
    tbl.push_back(mk(1, OPE, 0, 0,    1, 0, 1, 0, 1));
    tbl.push_back(mk(0, OPX, 0, 0,    1, 0, 0, 0, 1));
    tbl.push_back(mk(1, OPS, 0, 0,    1, 0, 0, 0, 1));
    tbl.push_back(mk(1, OPS, 0, 0,    1, 0, 1, 0, 1));
    tbl.push_back(mk(1, OPE, 0, 0,    1, 0, 0, 0, 1));
    tbl.push_back(mk(1, OPX, 0, 0,    1, 0, 0, 0, 1));
    tbl.push_back(mk(1, OPD, 0, 0,    0, 0, 0, 0, 1));
    tbl.push_back(mk(0, OPX, 0, 0,    1, 0, 0, 1, 1));
    tbl.push_back(mk(0, OPX, 0, 0,    1, 0, 0, 0, 1));

    foreach (tbl[i]) begin
      valid = tbl[i].v; opcode = tbl[i].op; vtx = tbl[i].vx; col = tbl[i].cx;
      rast_ready = tbl[i].rr;
      step();
      $display("vec %0d op=%h ready=%b tv=%b err=%b done=%b cnt=%0d", i, tbl[i].op, ready, tri_valid, err, draw_done, tri_count);
      chk($sformatf("vec%0d_ready", i), ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d_tv", i), tri_valid, tbl[i].e_tv);
      chk($sformatf("vec%0d_err", i), err, tbl[i].e_err);
      chk($sformatf("vec%0d_done", i), draw_done, tbl[i].e_done);
      chk($sformatf("vec%0d_cnt", i), tri_count, tbl[i].e_cnt);
      if (tbl[i].ev != 0) begin
        chk($sformatf("vec%0d_v", i), {v0, v1, v2}, {tbl[i].ev, tbl[i].ev + 32'd1, tbl[i].ev + 32'd2});
        chk($sformatf("vec%0d_c", i), {c0, c1, c2}, {tbl[i].ec, tbl[i].ec + 32'd1, tbl[i].ec + 32'd2});
      end
    end
    valid = 1'b0;

    // Full queue backpressure and in-order issue
    reset_dut();
    rast_ready = 1'b0;
    send(OPS, 0, 0);
    for (int n = 1; n <= 12; n++) send(OPV, n, n + 256);
    chk("full_ready", ready, 0);
    chk("full_tv", tri_valid, 1);
    chk("full_head_v0", v0, 1);
    chk("full_head_c2", c2, 3 + 256);
    valid = 1'b1; opcode = OPV; vtx = 13; col = 13 + 256;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_ready", ready, 0);
      chk("stall_head_v1", v1, 2);
    end
    rast_ready = 1'b1;
    step();
    chk("pop1_ready", ready, 1);
    chk("pop1_cnt", tri_count, 1);
    chk("pop1_head", v0, 4);
    step();
    chk("stalled_accept_cnt", tri_count, 2);
    chk("stalled_accept_head", v0, 7);
    valid = 1'b0;
    send(OPV, 14, 14 + 256);
    send(OPV, 15, 15 + 256);
    wait_cnt(5);
    chk("order_count", mon.size(), 5);
    for (int t = 0; t < 5 && t < mon.size(); t++) begin
      logic [127:0] e;
      e = {32'(3*t+1), 32'(3*t+2), 32'(3*t+3), 32'(3*t+1+256)};
      chk($sformatf("order_tri%0d", t), mon[t], e);
    end

    // DRAW flush waits for rasterizer idle
    reset_dut();
    rast_ready = 1'b0; rast_idle = 1'b0;
    send(OPS, 0, 0);
    for (int n = 21; n <= 26; n++) send(OPV, n, n);
    send(OPD, 0, 0);
    chk("draw_ready", ready, 0);
    chk("draw_err", err, 0);
    rast_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("drain_ready", ready, 0);
      chk("drain_done", draw_done, 0);
    end
    chk("drain_cnt", tri_count, 2);
    chk("drain_tv", tri_valid, 0);
    rast_idle = 1'b1;
    step();
    chk("drawdone_pulse", draw_done, 1);
    chk("drawdone_ready", ready, 1);
    step();
    chk("drawdone_once", draw_done, 0);

    // Reset mid-DRAIN abandons the queue
    reset_dut();
    rast_ready = 1'b0; rast_idle = 1'b0;
    send(OPS, 0, 0);
    for (int n = 31; n <= 39; n++) send(OPV, n, n);
    send(OPD, 0, 0);
    rast_ready = 1'b1;
    step();
    rast_ready = 1'b0;
    chk("pre_rst_cnt", tri_count, 1);
    chk("pre_rst_tv", tri_valid, 1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_tv", tri_valid, 0);
    chk("mid_rst_cnt", tri_count, 0);
    chk("mid_rst_ready", ready, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", ready, 1);
    mon.delete();
    rast_ready = 1'b1; rast_idle = 1'b1;
    send(OPS, 0, 0);
    for (int n = 41; n <= 43; n++) send(OPV, n, n);
    wait_cnt(1);
    chk("post_rst_tri", (mon.size() > 0) ? mon[0][127:96] : 32'd0, 41);

    // Five vertices then ENDPRIMITIVE
    reset_dut();
    rast_ready = 1'b1;
    send(OPS, 0, 0);
    for (int n = 1; n <= 5; n++) send(OPV, n, n + 256);
    send(OPE, 0, 0);
`ifdef RAST_SEQ_STRIP_EN
    chk("strip_end_err", err, 0);
    wait_cnt(3);
    chk("strip_count", mon.size(), 3);
    if (mon.size() == 3) begin
      chk("strip_tri0", mon[0], {32'd1, 32'd2, 32'd3, 32'd257});
      chk("strip_tri1", mon[1], {32'd3, 32'd2, 32'd4, 32'd259});
      chk("strip_tri2", mon[2], {32'd3, 32'd4, 32'd5, 32'd259});
    end
`else
    chk("list_end_err", err, 1);
    step(); step(); step();
    chk("list_cnt", tri_count, 1);
    chk("list_count", mon.size(), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
